// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl shared types: run FSM state and log entry width.
// CPU_LOG_TIMESTAMP_EN widens each log entry with a cycle timestamp.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } run_state_e;

`ifdef CPU_LOG_TIMESTAMP_EN
    localparam bit LOG_TS_EN = 1'b1;
`else
    localparam bit LOG_TS_EN = 1'b0;
`endif

    function automatic int log_w(input int data_w, input int ts_w);
        return LOG_TS_EN ? ts_w + data_w : data_w;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl bus: board/bench side (master) and controller (slave).
// Carries run control, cpu status and the log FIFO read port.
interface cpu_run_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 24,
    parameter int LW     = 8
);
    logic              start;
    logic              step_mode;
    logic              step;
    logic              halt_in;
    logic [DATA_W-1:0] cpu_out;
    logic              cpu_reset;
    logic              cpu_clk_en;
    logic              running;
    logic              done;
    logic              timed_out;
    logic [CNT_W-1:0]  cycle_cnt;
    logic              log_valid;
    logic              log_ready;
    logic [LW-1:0]     log_data;
    logic              log_ovf;

    modport master (
        output start, step_mode, step, halt_in, cpu_out, log_ready,
        input  cpu_reset, cpu_clk_en, running, done, timed_out,
        input  cycle_cnt, log_valid, log_data, log_ovf
    );

    modport slave (
        input  start, step_mode, step, halt_in, cpu_out, log_ready,
        output cpu_reset, cpu_clk_en, running, done, timed_out,
        output cycle_cnt, log_valid, log_data, log_ovf
    );

endinterface

// File: rtl/cpu_run_ctrl_log_fifo.sv
// cpu_log_fifo: synchronous first-word-fall-through FIFO.
// A push into a full FIFO is accepted only alongside a pop.
module cpu_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];

    // Pointers wrap naturally; count tells full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push}
                               - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: cpu reset sequencing, clock-enable gating, run length
// and cpu_out change log. Option macro: CPU_LOG_TIMESTAMP_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 5,
    parameter int CNT_W      = 24,
    parameter int MAX_CYCLES = 50000,
    parameter int LOG_DEPTH  = 16,
    parameter int TS_W       = 16
) (
    input logic           clk,
    input logic           reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int LW = log_w(DATA_W, TS_W);
    localparam int RW = $clog2(RST_CYCLES + 1);

    run_state_e        state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timed_q, timed_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              en_q;
    logic              smode_q;
    logic              step_q;
    logic              clk_en;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [LW-1:0]     entry;

`ifdef CPU_LOG_TIMESTAMP_EN
    assign entry = {cnt_q[TS_W-1:0], bus.cpu_out};
`else
    assign entry = bus.cpu_out;
`endif

    assign pop = !empty && bus.log_ready;

    // Next state, run counters and change detection.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        cnt_d   = cnt_q;
        timed_d = timed_q;
        ovf_d   = ovf_q;
        prev_d  = prev_q;
        clk_en  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RST;
                    rcnt_d  = '0;
                    cnt_d   = '0;
                    timed_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_RST: begin
                if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                    prev_d  = bus.cpu_out;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            S_RUN: begin
                clk_en = !bus.halt_in && (smode_q ? step_q : 1'b1);
                if (clk_en && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (bus.halt_in) begin
                    state_d = S_DONE;
                end else if (clk_en &&
                             cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d = S_DONE;
                    timed_d = 1'b1;
                end
                // cpu_out can only move after an enabled cycle.
                if (en_q && bus.cpu_out != prev_q) begin
                    push   = 1'b1;
                    prev_d = bus.cpu_out;
                    if (full && !pop) ovf_d = 1'b1;
                end
            end
        endcase
    end

    // State and registered step controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            cnt_q   <= '0;
            timed_q <= 1'b0;
            ovf_q   <= 1'b0;
            prev_q  <= '0;
            en_q    <= 1'b0;
            smode_q <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            cnt_q   <= cnt_d;
            timed_q <= timed_d;
            ovf_q   <= ovf_d;
            prev_q  <= prev_d;
            en_q    <= clk_en;
            smode_q <= bus.step_mode;
            step_q  <= bus.step;
        end
    end

    assign bus.cpu_reset  = (state_q == S_IDLE) || (state_q == S_RST);
    assign bus.cpu_clk_en = clk_en;
    assign bus.running    = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.timed_out  = timed_q;
    assign bus.cycle_cnt  = cnt_q;
    assign bus.log_ovf    = ovf_q;
    assign bus.log_valid  = !empty;

    cpu_log_fifo #(
        .WIDTH (LW),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry),
        .rdata_o (bus.log_data),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed scenarios plus random stimulus against
// a behavioural model of the run controller and its change log.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int DW    = 8;
    localparam int CW    = 24;
    localparam int MAXC  = 100;
    localparam int DEPTH = 16;
    localparam int TSW   = 16;
    localparam int RSTC  = 5;
    localparam int LW    = log_w(DW, TSW);
    localparam int CSAT  = (1 << CW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_RST  = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    logic rst_n;

    cpu_run_ctrl_if #(.DATA_W(DW), .CNT_W(CW), .LW(LW)) bus ();

    cpu_run_ctrl #(
        .DATA_W     (DW),
        .RST_CYCLES (RSTC),
        .CNT_W      (CW),
        .MAX_CYCLES (MAXC),
        .LOG_DEPTH  (DEPTH),
        .TS_W       (TSW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // model
    int          m_phase;
    int          m_rst_left;
    int          m_cnt;
    bit          m_timed;
    bit          m_ovf;
    bit          m_was_en;
    bit          m_smode;
    bit          m_step;
    bit          last_en;
    bit          cpu_rand;
    logic [DW-1:0] m_prev;
    logic [LW-1:0] q[$];
    logic [DW-1:0] script[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit model_en();
        return m_phase == P_RUN && !bus.halt_in &&
               (m_smode ? m_step : 1'b1);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_rst_left = 0;
        m_cnt = 0;
        m_timed = 0;
        m_ovf = 0;
        m_was_en = 0;
        m_smode = 0;
        m_step = 0;
        last_en = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit en;
        bit pop;
        bit pushq;
        logic [LW-1:0] ent;
        en = model_en();
        pop = (q.size() > 0) && bus.log_ready;
        pushq = 0;
`ifdef CPU_LOG_TIMESTAMP_EN
        ent = {m_cnt[TSW-1:0], bus.cpu_out};
`else
        ent = bus.cpu_out;
`endif
        if (m_phase == P_RUN && m_was_en && bus.cpu_out != m_prev) begin
            m_prev = bus.cpu_out;
            if (q.size() < DEPTH || pop) pushq = 1;
            else m_ovf = 1;
        end
        if (pop) void'(q.pop_front());
        if (pushq) q.push_back(ent);
        case (m_phase)
            P_IDLE, P_DONE: begin
                if (bus.start) begin
                    m_phase = P_RST;
                    m_rst_left = RSTC;
                    m_cnt = 0;
                    m_timed = 0;
                    m_ovf = 0;
                end
            end
            P_RST: begin
                m_rst_left--;
                if (m_rst_left == 0) begin
                    m_phase = P_RUN;
                    m_prev = bus.cpu_out;
                end
            end
            P_RUN: begin
                if (en && m_cnt < CSAT) m_cnt++;
                if (bus.halt_in) m_phase = P_DONE;
                else if (m_cnt == MAXC) begin
                    m_phase = P_DONE;
                    m_timed = 1;
                end
            end
            default: ;
        endcase
        last_en = en;
        m_was_en = en;
        m_smode = bus.step_mode;
        m_step = bus.step;
    endtask

    // edge: model follows the DUT, then the toy cpu reacts
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_phase == P_IDLE || m_phase == P_RST) begin
            bus.cpu_out = '0;
        end else if (last_en) begin
            if (script.size() > 0) bus.cpu_out = script.pop_front();
            else if (cpu_rand && $urandom_range(0, 1) == 1)
                bus.cpu_out = DW'($urandom);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk("cpu_reset", bus.cpu_reset,
            m_phase == P_IDLE || m_phase == P_RST);
        chk("cpu_clk_en", bus.cpu_clk_en, model_en());
        chk("running", bus.running, m_phase == P_RUN);
        chk("done", bus.done, m_phase == P_DONE);
        chk("timed_out", bus.timed_out, m_timed);
        chk("cycle_cnt", bus.cycle_cnt, m_cnt);
        chk("log_ovf", bus.log_ovf, m_ovf);
        chk("log_valid", bus.log_valid, q.size() > 0);
        if (q.size() > 0) chk("log_data", bus.log_data, q[0]);
    endtask

    task automatic cyc();
        tick();
        sample();
    endtask

    task automatic start_pulse();
        tick();
        bus.start = 1'b1;
        sample();
        tick();
        bus.start = 1'b0;
        sample();
    endtask

    task automatic halt_pulse();
        tick();
        bus.halt_in = 1'b1;
        sample();
        tick();
        bus.halt_in = 1'b0;
        sample();
    endtask

    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        model_reset();
        sample();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int lr_pct;
        n_chk = 0;
        n_pass = 0;
        cpu_rand = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
        bus.halt_in = 1'b0;
        bus.cpu_out = '0;
        bus.log_ready = 1'b0;
        model_reset();
        sample();
        chk("rst_cpu_reset", bus.cpu_reset, 1'b1);
        chk("rst_cnt", bus.cycle_cnt, 0);
        #1 rst_n = 1'b1;

        // halt at cycle 37
        start_pulse();
        for (int i = 0; i < 200 && !(m_phase == P_RUN && m_cnt == 37); i++)
            cyc();
        bus.halt_in = 1'b1;
        #1 chk("halt_clk_en", bus.cpu_clk_en, 1'b0);
        tick();
        bus.halt_in = 1'b0;
        sample();
        chk("halt_done", bus.done, 1'b1);
        chk("halt_cnt", bus.cycle_cnt, 37);
        chk("halt_timed", bus.timed_out, 1'b0);

        // reset sequence length from DONE
        tick();
        bus.start = 1'b1;
        sample();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.start = 1'b0;
            sample();
            if (bus.cpu_clk_en) break;
            if (bus.cpu_reset) n++;
        end
        chk("rst_len", n, RSTC);
        chk("rst_running", bus.running, 1'b1);

        // timeout
        for (int i = 0; i < 300 && !bus.done; i++) cyc();
        chk("to_done", bus.done, 1'b1);
        chk("to_timed", bus.timed_out, 1'b1);
        chk("to_cnt", bus.cycle_cnt, MAXC);
        start_pulse();
        chk("to_restart_timed", bus.timed_out, 1'b0);
        chk("to_restart_cnt", bus.cycle_cnt, 0);

        // single step
        bus.step_mode = 1'b1;
        for (int i = 0; i < 20 && !bus.running; i++) cyc();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.step = (i == 2 || i == 9 || i == 15);
            sample();
            if (bus.cpu_clk_en) n++;
        end
        bus.step = 1'b0;
        chk("step_en", n, 3);
        chk("step_cnt", bus.cycle_cnt, 3);
        halt_pulse();
        bus.step_mode = 1'b0;

        // log order
        reset_pulse();
        script = '{8'h11, 8'h11, 8'h2A};
        start_pulse();
        repeat (30) cyc();
        halt_pulse();
        chk("log_valid1", bus.log_valid, 1'b1);
        chk("log_first", bus.log_data[DW-1:0], 8'h11);
        tick();
        bus.log_ready = 1'b1;
        sample();
        tick();
        bus.log_ready = 1'b0;
        sample();
        chk("log_second", bus.log_data[DW-1:0], 8'h2A);

        // overflow: 17 changes into 16 entries
        reset_pulse();
        for (int i = 1; i <= 17; i++) script.push_back(DW'(i));
        start_pulse();
        repeat (40) cyc();
        halt_pulse();
        chk("ovf_flag", bus.log_ovf, 1'b1);
        chk("ovf_head", bus.log_data[DW-1:0], 8'h01);

        // async reset mid-run
        cpu_rand = 1;
        start_pulse();
        repeat (12) cyc();
        tick();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_cpu_reset", bus.cpu_reset, 1'b1);
        chk("ar_clk_en", bus.cpu_clk_en, 1'b0);
        chk("ar_running", bus.running, 1'b0);
        chk("ar_valid", bus.log_valid, 1'b0);
        chk("ar_cnt", bus.cycle_cnt, 0);
        sample();
        #1 rst_n = 1'b1;

        // random
        lr_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: lr_pct = 5;
                    1: lr_pct = 50;
                    default: lr_pct = 95;
                endcase
            end
            bus.start = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 49) == 0) bus.step_mode = ~bus.step_mode;
            bus.step = ($urandom_range(0, 2) == 0);
            bus.halt_in = ($urandom_range(0, 59) == 0);
            bus.log_ready = ($urandom_range(0, 99) < lr_pct);
            sample();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
